// File: rtl/dct8_butterfly4_if.sv
// Stream interface for the 8-point DCT first-stage butterfly: serial samples in, butterfly results out.
interface dct8_butterfly4_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned OUT_W = DATA_WIDTH + 1;

    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_sample;
    logic                         in_flush;
    logic                         out_valid;
    logic signed [OUT_W-1:0]      out_sample;
    logic [2:0]                   out_index;
    logic                         out_last;

    modport master (
        output in_valid, in_sample, in_flush,
        input  out_valid, out_sample, out_index, out_last
    );

    modport slave (
        input  in_valid, in_sample, in_flush,
        output out_valid, out_sample, out_index, out_last
    );
endinterface

// File: rtl/dct8_butterfly4.sv
// 8-point DCT first-stage butterfly with ping-pong banks: fills one bank serially while draining the other.
// Optional macro DCT8_BFLY_SAT_EN saturates each result to the signed DATA_WIDTH range.
module dct8_butterfly4 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dct8_butterfly4_if.slave  bus
);
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned OUT_W = DATA_WIDTH + 1;

    localparam logic signed [OUT_W-1:0] SAT_MAX = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {2'b11, {(DW-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0] mem [2][8];

    logic [2:0] wr_cnt_q,  wr_cnt_d;
    logic       wr_bank_q, wr_bank_d;
    logic [2:0] rd_idx_q,  rd_idx_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q,    full_d;

    logic                    out_valid_q,  out_valid_d;
    logic signed [OUT_W-1:0] out_sample_q, out_sample_d;
    logic [2:0]              out_index_q,  out_index_d;
    logic                    out_last_q,   out_last_d;

    logic                    accept;
    logic                    complete;
    logic                    emit;
    logic [2:0]              emit_idx;
    logic [2:0]              idx_a;
    logic [2:0]              idx_b;
    logic signed [DW-1:0]    op_a;
    logic signed [DW-1:0]    op_b;
    logic signed [OUT_W-1:0] op_a_ext;
    logic signed [OUT_W-1:0] op_b_ext;
    logic signed [OUT_W-1:0] res_raw;
    logic signed [OUT_W-1:0] res;

    // Next-state, bank bookkeeping and registered-output computation
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        wr_bank_d    = wr_bank_q;
        rd_idx_d     = rd_idx_q;
        rd_bank_d    = rd_bank_q;
        full_d       = full_q;
        out_valid_d  = 1'b0;
        out_sample_d = '0;
        out_index_d  = '0;
        out_last_d   = 1'b0;
        emit         = 1'b0;
        emit_idx     = rd_idx_q;
        idx_a        = '0;
        idx_b        = '0;
        op_a         = '0;
        op_b         = '0;
        op_a_ext     = '0;
        op_b_ext     = '0;
        res_raw      = '0;
        res          = '0;

        // Flush takes priority over a coincident sample
        accept   = bus.in_valid && !bus.in_flush;
        complete = accept && (wr_cnt_q == 3'd7);

        if (bus.in_flush) begin
            wr_cnt_d = '0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
            if (complete) begin
                wr_bank_d = ~wr_bank_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    emit     = 1'b1;
                    emit_idx = 3'd0;
                    rd_idx_d = 3'd1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                emit     = 1'b1;
                emit_idx = rd_idx_q;
                rd_idx_d = rd_idx_q + 3'd1;
                if (rd_idx_q == 3'd7) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    // Stay in DRAIN (index wrapped to 0) when the other bank is already complete
                    if (full_q[~rd_bank_q] || complete) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
        end

        // Pair j with 7-j; upper half of the index space takes the difference
        idx_a    = {1'b0, emit_idx[1:0]};
        idx_b    = {1'b1, ~emit_idx[1:0]};
        op_a     = mem[rd_bank_q][idx_a];
        op_b     = mem[rd_bank_q][idx_b];
        op_a_ext = OUT_W'(op_a);
        op_b_ext = OUT_W'(op_b);
        res_raw  = emit_idx[2] ? (op_a_ext - op_b_ext) : (op_a_ext + op_b_ext);

`ifdef DCT8_BFLY_SAT_EN
        if (res_raw > SAT_MAX) begin
            res = SAT_MAX;
        end else if (res_raw < SAT_MIN) begin
            res = SAT_MIN;
        end else begin
            res = res_raw;
        end
`else
        res = res_raw;
`endif

        if (emit) begin
            out_valid_d  = 1'b1;
            out_sample_d = res;
            out_index_d  = emit_idx;
            out_last_d   = (emit_idx == 3'd7);
        end
    end

    // Sample storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank_q][wr_cnt_q] <= bus.in_sample;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_idx_q     <= '0;
            rd_bank_q    <= 1'b0;
            full_q       <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            wr_bank_q    <= wr_bank_d;
            rd_idx_q     <= rd_idx_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign bus.out_index  = out_index_q;
    assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_dct8_butterfly4.sv
// Directed bench for dct8_butterfly4: single, back-to-back, flush, gapped, overflow and reset-mid-drain cases.
module tb_dct8_butterfly4;
    localparam int unsigned DW = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    dct8_butterfly4_if #(.DATA_WIDTH(DW)) bus ();

    dct8_butterfly4 #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'(v);
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic check_out(input string tag, input int i, input int e);
        check({tag, "_valid"},  bus.out_valid,  1);
        check({tag, "_index"},  bus.out_index,  i);
        check({tag, "_sample"}, bus.out_sample, e);
        check({tag, "_last"},   bus.out_last,   (i == 7) ? 1 : 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"},  bus.out_valid,  0);
        check({tag, "_sample"}, bus.out_sample, 0);
        check({tag, "_index"},  bus.out_index,  0);
        check({tag, "_last"},   bus.out_last,   0);
    endtask

    task automatic expect_burst(input string tag, input int e [8]);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out(tag, i, e[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int e_basic [8] = '{9, 9, 9, 9, -7, -5, -3, -1};
        int e_b2b1  [8] = '{7, 7, 7, 7, -7, -5, -3, -1};
        int e_b2b2  [8] = '{23, 23, 23, 23, -7, -5, -3, -1};
        int e_ten   [8] = '{90, 90, 90, 90, -70, -50, -30, -10};
`ifdef DCT8_BFLY_SAT_EN
        int e_ovf   [8] = '{32767, 0, 0, -1, 0, 0, 0, -32768};
`else
        int e_ovf   [8] = '{65534, 0, 0, -1, 0, 0, 0, -65535};
`endif
        total  = 0;
        passed = 0;
        failed = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.in_flush  = 1'b0;

        // Reset state
        #1;
        check_idle("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Single block, output begins the edge after x7
        for (int v = 1; v <= 8; v++) send(v);
        check("single_early_valid", bus.out_valid, 0);
        expect_burst("single", e_basic);
        tick();
        check_idle("single_after");

        // Back-to-back blocks: second block fills while the first drains
        for (int v = 0; v < 8; v++) send(v);
        for (int v = 8; v < 16; v++) begin
            bus.in_valid  = 1'b1;
            bus.in_sample = 16'(v);
            tick();
            check_out("b2b_blk1", v - 8, e_b2b1[v - 8]);
        end
        bus.in_valid = 1'b0;
        expect_burst("b2b_blk2", e_b2b2);
        tick();
        check_idle("b2b_after");

        // Flush with coincident valid drops the partial block and the sample
        for (int v = 0; v < 5; v++) send(100 + v);
        bus.in_flush  = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'(555);
        tick();
        bus.in_flush  = 1'b0;
        bus.in_valid  = 1'b0;
        check("flush_no_out", bus.out_valid, 0);
        for (int v = 1; v <= 7; v++) begin
            send(v);
            check("flush_fill_no_out", bus.out_valid, 0);
        end
        send(8);
        expect_burst("flush", e_basic);
        tick();
        check_idle("flush_after");
        tick();
        check("flush_single_block", bus.out_valid, 0);

        // Gapped input
        for (int v = 1; v <= 8; v++) begin
            send(v);
            if (v < 8) begin
                tick();
                check("gap_no_out", bus.out_valid, 0);
            end
        end
        expect_burst("gapped", e_basic);
        tick();
        check_idle("gapped_after");

        // Overflow boundaries at full and saturated precision
        send(32767); send(0); send(0); send(-32768);
        send(32767); send(0); send(0); send(32767);
        expect_burst("overflow", e_ovf);
        tick();
        check_idle("overflow_after");

        // Reset mid-drain at out_index 3
        for (int v = 1; v <= 8; v++) send(v);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("pre_reset", i, e_basic[i]);
        end
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_abandon", bus.out_valid, 0);
        tick();
        check("post_reset_abandon2", bus.out_valid, 0);

        // Reset during fill, then a fresh block must start at x0
        send(1000); send(2000); send(3000);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 1; v <= 8; v++) send(v * 10);
        expect_burst("post_reset", e_ten);
        tick();
        check_idle("post_reset_after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
